// File: rtl/dmem_port_arbiter_if.sv
// One requester's view of the shared data-memory port.
// The requester drives the request and payload, and receives ack and read data back.
interface dmem_port_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [3:0]    amp;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, amp, addr, wdata, input ack, rdata);
    modport slave  (input req, we, amp, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single async-read dmem port.
// The grant is combinational; the only registered state is the fairness state.
module dmem_port_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int POLICY     = 0,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rstn,
    dmem_port_arbiter_if.slave  m0,
    dmem_port_arbiter_if.slave  m1,
    output logic                mem_we,
    output logic [3:0]          mem_amp,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wd,
    input  logic [DW-1:0]       mem_rd,
    output logic                m1_starved
);

    logic gnt0, gnt1;
    logic ack0, ack1;

    // Reset gates the acks directly, so an access in flight is dropped at once
    assign ack0 = rstn & gnt0;
    assign ack1 = rstn & gnt1;

    generate
        if (POLICY == 0) begin : g_prio
            localparam int WCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
            localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_MAX);

            logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
            logic           starved;

            assign starved    = (wait_cnt_q == WAIT_MAX);
            assign gnt1       = m1.req & (starved | ~m0.req);
            assign gnt0       = m0.req & ~gnt1;
            assign m1_starved = rstn & starved;

            always_comb begin
                wait_cnt_d = '0;
                if (m1.req & ~ack1)
                    wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 1'b1;
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    wait_cnt_q <= '0;
                else
                    wait_cnt_q <= wait_cnt_d;
            end
        end else begin : g_rr
            // last_q holds the most recently served port; it resets to 1 so that port 0 wins the first tie
            logic last_q, last_d;

            assign gnt1       = m1.req & (~m0.req | ~last_q);
            assign gnt0       = m0.req & ~gnt1;
            assign m1_starved = 1'b0;

            always_comb begin
                last_d = last_q;
                if (ack0)
                    last_d = 1'b0;
                else if (ack1)
                    last_d = 1'b1;
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    last_q <= 1'b1;
                else
                    last_q <= last_d;
            end
        end
    endgenerate

    always_comb begin
        mem_we   = 1'b0;
        mem_amp  = '0;
        mem_addr = '0;
        mem_wd   = '0;
        if (ack0) begin
            mem_we   = m0.we;
            mem_amp  = m0.amp;
            mem_addr = m0.addr;
            mem_wd   = m0.wdata;
        end else if (ack1) begin
            mem_we   = m1.we;
            mem_amp  = m1.amp;
            mem_addr = m1.addr;
            mem_wd   = m1.wdata;
        end
    end

    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.rdata = ack0 ? mem_rd : '0;
    assign m1.rdata = ack1 ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (priority, round-robin, STARVE_MAX=0) share one stimulus.
// Each instance has its own memory, and all outputs are compared against a behavioural model.
module tb_dmem_port_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rstn;
    logic clr;
    logic r0, r1, we0, we1;
    logic [3:0]    amp0, amp1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;

    logic [ND-1:0] ack0_v, ack1_v, st_v, mwe_v;
    logic [AW-1:0] maddr_v [ND];
    logic [DW-1:0] rd0_v [ND];
    logic [DW-1:0] rd1_v [ND];

    int n_pass = 0;
    int n_chk  = 0;

    // model state
    int waited [ND];
    int last   [ND];
    logic [DW-1:0] sh [ND][2**AW];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int POL = (d == 1) ? 1 : 0;
        localparam int SMX = (d == 2) ? 0 : 3;
        dmem_port_arbiter_if #(.AW(AW), .DW(DW)) p0 ();
        dmem_port_arbiter_if #(.AW(AW), .DW(DW)) p1 ();
        logic          mem_we, starved;
        logic [3:0]    mem_amp;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wd, mem_rd;
        logic [DW-1:0] mem [2**AW];

        assign p0.req = r0;  assign p0.we = we0;  assign p0.amp = amp0;
        assign p0.addr = a0; assign p0.wdata = wd0;
        assign p1.req = r1;  assign p1.we = we1;  assign p1.amp = amp1;
        assign p1.addr = a1; assign p1.wdata = wd1;

        dmem_port_arbiter #(.AW(AW), .DW(DW), .POLICY(POL), .STARVE_MAX(SMX)) u_dut (
            .clk(clk), .rstn(rstn), .m0(p0), .m1(p1),
            .mem_we(mem_we), .mem_amp(mem_amp), .mem_addr(mem_addr),
            .mem_wd(mem_wd), .mem_rd(mem_rd), .m1_starved(starved)
        );

        assign mem_rd = mem[mem_addr];
        always @(posedge clk) begin
            if (clr) begin
                for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            end else if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_amp[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end

        assign ack0_v[d]  = p0.ack;
        assign ack1_v[d]  = p1.ack;
        assign st_v[d]    = starved;
        assign mwe_v[d]   = mem_we;
        assign maddr_v[d] = mem_addr;
        assign rd0_v[d]   = p0.rdata;
        assign rd1_v[d]   = p1.rdata;
    end

    function automatic int pol_of(int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int sm_of(int d);
        return (d == 2) ? 0 : 3;
    endfunction

    // 0 = no grant, 1 = port 0, 2 = port 1
    function automatic int exp_gnt(int d);
        if (!rstn) return 0;
        if (pol_of(d) == 0) begin
            if (r1 && waited[d] >= sm_of(d)) return 2;
            if (r0) return 1;
            if (r1) return 2;
            return 0;
        end
        if (r0 && r1) return (last[d] == 0) ? 2 : 1;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    function automatic logic exp_st(int d);
        return (pol_of(d) == 0) && rstn && (waited[d] == sm_of(d));
    endfunction

    task automatic sh_write(int d, logic [AW-1:0] ad, logic [3:0] m, logic [DW-1:0] v);
        for (int b = 0; b < 4; b++)
            if (m[b]) sh[d][ad][8*b +: 8] = v[8*b +: 8];
    endtask

    task automatic model_tick();
        for (int d = 0; d < ND; d++) begin
            int g;
            g = exp_gnt(d);
            if (!rstn) begin
                waited[d] = 0;
                last[d]   = 1;
            end else begin
                if (g == 1 && we0) sh_write(d, a0, amp0, wd0);
                else if (g == 2 && we1) sh_write(d, a1, amp1, wd1);
                if (pol_of(d) == 0)
                    waited[d] = (r1 && g != 2) ? ((waited[d] < sm_of(d)) ? waited[d] + 1 : waited[d]) : 0;
                else if (g != 0)
                    last[d] = g - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle_all();
        r0 = 0; r1 = 0; we0 = 0; we1 = 0; amp0 = '0; amp1 = '0;
        a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic apply_reset();
        idle_all();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        r0 = 1; r1 = 1; we0 = 1; amp0 = 4'hF;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_chk++; if (ack0_v[d] !== 1'b0) $display("FAIL rst_ack0 dut%0d got %b exp 0", d, ack0_v[d]); else n_pass++;
            n_chk++; if (ack1_v[d] !== 1'b0) $display("FAIL rst_ack1 dut%0d got %b exp 0", d, ack1_v[d]); else n_pass++;
            n_chk++; if (mwe_v[d] !== 1'b0) $display("FAIL rst_mem_we dut%0d got %b exp 0", d, mwe_v[d]); else n_pass++;
            n_chk++; if (st_v[d] !== 1'b0) $display("FAIL rst_starved dut%0d got %b exp 0", d, st_v[d]); else n_pass++;
        end
        tick();
        rstn = 1'b1;
        we0 = 0;
        #1;
        n_chk++; if (ack0_v !== 3'b011) $display("FAIL post_rst_ack0 got %b exp 011", ack0_v); else n_pass++;
        n_chk++; if (ack1_v !== 3'b100) $display("FAIL post_rst_ack1 got %b exp 100", ack1_v); else n_pass++;
        n_chk++; if (st_v !== 3'b100) $display("FAIL post_rst_starved got %b exp 100", st_v); else n_pass++;
        tick();
        idle_all();
    endtask

    task automatic test_write_read();
        r0 = 1; we0 = 1; a0 = 7'h05; wd0 = 32'hDEADBEEF; amp0 = 4'hF;
        @(negedge clk);
        n_chk++; if (mwe_v !== 3'b111) $display("FAIL wr_mem_we got %b exp 111", mwe_v); else n_pass++;
        n_chk++; if (maddr_v[0] !== 7'h05) $display("FAIL wr_mem_addr got %h exp 05", maddr_v[0]); else n_pass++;
        n_chk++; if (ack0_v !== 3'b111) $display("FAIL wr_ack0 got %b exp 111", ack0_v); else n_pass++;
        tick();
        we0 = 0;
        @(negedge clk);
        n_chk++; if (ack0_v[0] !== 1'b1) $display("FAIL rd_ack0 got %b exp 1", ack0_v[0]); else n_pass++;
        n_chk++; if (rd0_v[0] !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", rd0_v[0]); else n_pass++;
        tick();
        idle_all();
    endtask

    task automatic test_tie_patterns();
        apply_reset();
        r0 = 1; r1 = 1; a0 = 7'h01; a1 = 7'h02;
        for (int c = 0; c < 8; c++) begin
            logic sv, alt;
            logic [2:0] e0, e1, es;
            sv  = (c % 4 == 3);
            alt = (c % 2 == 1);
            e1  = {1'b1, alt, sv};
            e0  = {1'b0, ~alt, ~sv};
            es  = {1'b1, 1'b0, sv};
            @(negedge clk);
            n_chk++; if (ack0_v !== e0) $display("FAIL tie_ack0 c%0d got %b exp %b", c, ack0_v, e0); else n_pass++;
            n_chk++; if (ack1_v !== e1) $display("FAIL tie_ack1 c%0d got %b exp %b", c, ack1_v, e1); else n_pass++;
            n_chk++; if (st_v !== es) $display("FAIL tie_starved c%0d got %b exp %b", c, st_v, es); else n_pass++;
            n_chk++; if ((ack0_v & ack1_v) !== 3'b000) $display("FAIL tie_double_ack c%0d got %b exp 000", c, ack0_v & ack1_v); else n_pass++;
            tick();
        end
        idle_all();
    endtask

    task automatic test_rr_lone();
        r1 = 1; amp1 = 4'hF;
        for (int c = 0; c < 6; c++) begin
            we1 = 1'($urandom_range(0, 1));
            a1  = 7'($urandom_range(64, 79));
            wd1 = $urandom;
            @(negedge clk);
            n_chk++; if (ack1_v[1] !== 1'b1) $display("FAIL rr_lone_ack1 c%0d got %b exp 1", c, ack1_v[1]); else n_pass++;
            n_chk++; if (mwe_v[1] !== we1) $display("FAIL rr_lone_mem_we c%0d got %b exp %b", c, mwe_v[1], we1); else n_pass++;
            tick();
        end
        idle_all();
    endtask

    task automatic test_byte_lane();
        r1 = 1; we1 = 1; a1 = 7'h10; wd1 = 32'h11223344; amp1 = 4'hF;
        tick();
        wd1 = 32'h0000AB00; amp1 = 4'b0010;
        tick();
        we1 = 0; amp1 = 4'h0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_chk++; if (rd1_v[d] !== 32'h1122AB44) $display("FAIL byte_lane dut%0d got %h exp 1122ab44", d, rd1_v[d]); else n_pass++;
        end
        tick();
        idle_all();
    endtask

    task automatic test_reset_mid();
        r0 = 1; we0 = 1; a0 = 7'h20; wd0 = 32'hCAFEF00D; amp0 = 4'hF;
        tick();
        wd0 = 32'h12345678;
        #2;
        n_chk++; if (ack0_v[0] !== 1'b1) $display("FAIL mid_pre_ack0 got %b exp 1", ack0_v[0]); else n_pass++;
        n_chk++; if (mwe_v[0] !== 1'b1) $display("FAIL mid_pre_mem_we got %b exp 1", mwe_v[0]); else n_pass++;
        rstn = 1'b0;
        #1;
        n_chk++; if (ack0_v !== 3'b000) $display("FAIL mid_ack0 got %b exp 000", ack0_v); else n_pass++;
        n_chk++; if (mwe_v !== 3'b000) $display("FAIL mid_mem_we got %b exp 000", mwe_v); else n_pass++;
        tick();
        rstn = 1'b1;
        we0 = 0; r1 = 1; a1 = 7'h21;
        @(negedge clk);
        n_chk++; if (rd0_v[0] !== 32'hCAFEF00D) $display("FAIL mid_keep dut0 got %h exp cafef00d", rd0_v[0]); else n_pass++;
        n_chk++; if (rd0_v[1] !== 32'hCAFEF00D) $display("FAIL mid_keep dut1 got %h exp cafef00d", rd0_v[1]); else n_pass++;
        n_chk++; if (ack0_v[1:0] !== 2'b11) $display("FAIL mid_first_tie got %b exp 11", ack0_v[1:0]); else n_pass++;
        n_chk++; if (st_v[0] !== 1'b0) $display("FAIL mid_wait_cnt got %b exp 0", st_v[0]); else n_pass++;
        tick();
        idle_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            r0   = ($urandom_range(0, 99) < 70);
            r1   = ($urandom_range(0, 99) < 70);
            we0  = 1'($urandom_range(0, 1));
            we1  = 1'($urandom_range(0, 1));
            amp0 = 4'($urandom);
            amp1 = 4'($urandom);
            a0   = 7'($urandom_range(0, 15));
            a1   = 7'($urandom_range(0, 15));
            wd0  = $urandom;
            wd1  = $urandom;
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                int g;
                logic ewe;
                logic [AW-1:0] ead;
                logic [DW-1:0] er0, er1;
                g   = exp_gnt(d);
                ewe = (g == 1) ? we0 : (g == 2) ? we1 : 1'b0;
                ead = (g == 1) ? a0 : (g == 2) ? a1 : '0;
                er0 = (g == 1) ? sh[d][a0] : '0;
                er1 = (g == 2) ? sh[d][a1] : '0;
                n_chk++; if (ack0_v[d] !== (g == 1)) $display("FAIL rnd_ack0 c%0d dut%0d got %b exp %b", c, d, ack0_v[d], g == 1); else n_pass++;
                n_chk++; if (ack1_v[d] !== (g == 2)) $display("FAIL rnd_ack1 c%0d dut%0d got %b exp %b", c, d, ack1_v[d], g == 2); else n_pass++;
                n_chk++; if (st_v[d] !== exp_st(d)) $display("FAIL rnd_starved c%0d dut%0d got %b exp %b", c, d, st_v[d], exp_st(d)); else n_pass++;
                n_chk++; if (mwe_v[d] !== ewe) $display("FAIL rnd_mem_we c%0d dut%0d got %b exp %b", c, d, mwe_v[d], ewe); else n_pass++;
                n_chk++; if (maddr_v[d] !== ead) $display("FAIL rnd_mem_addr c%0d dut%0d got %h exp %h", c, d, maddr_v[d], ead); else n_pass++;
                n_chk++; if (rd0_v[d] !== er0) $display("FAIL rnd_rdata0 c%0d dut%0d got %h exp %h", c, d, rd0_v[d], er0); else n_pass++;
                n_chk++; if (rd1_v[d] !== er1) $display("FAIL rnd_rdata1 c%0d dut%0d got %h exp %h", c, d, rd1_v[d], er1); else n_pass++;
            end
            tick();
        end
        idle_all();
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            waited[d] = 0;
            last[d]   = 1;
            for (int i = 0; i < 2**AW; i++) sh[d][i] = '0;
        end
        clr = 1'b1;
        apply_reset();
        clr = 1'b0;
        test_reset();
        test_write_read();
        test_tie_patterns();
        test_rr_lone();
        test_byte_lane();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
